// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The responder's optional fault checking is enabled with IMEM_FAULT_CHECK_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP          = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// Word storage: one write port and one registered read port, no reset.
// The read register updates only when re_i is high, so it holds a captured word.
module imem_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Read and write share an edge; the read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding fetch, WAIT_CYCLES wait states.
// Define IMEM_FAULT_CHECK_EN to flag misaligned or out-of-window fetches.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE_DEFAULT,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_inst,
  output logic                           rsp_err,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  imem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic [31:0] fetch_addr;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        fault;
  logic        capture;
  logic [31:0] rd_data;

  // With zero wait states the capture edge is the accept edge, so the
  // address must come straight from the request port.
  assign fetch_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign offset     = fetch_addr - BASE_ADDR;
  assign idx        = AW'(offset >> 2);

`ifdef IMEM_FAULT_CHECK_EN
  localparam logic [33:0] SPAN = 34'(DEPTH_WORDS) << 2;
  assign fault = (fetch_addr[1:0] != 2'b00) || ({2'b00, offset} >= SPAN);
`else
  assign fault = 1'b0;
`endif

  assign capture = (state_d == RESP) && (state_q != RESP);

  imem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (load_en),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (capture),
    .raddr_i (idx),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = capture ? fault : err_q;
  end

  // Outputs are gated by state so reset yields a zero response without
  // needing a reset on the storage read register.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_inst  = 32'h0;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_inst  = err_q ? 32'h0 : rd_data;
      end
      default: ;
    endcase
  end

endmodule
